// File: rtl/ll1_merge_scheduler_pkg.sv
// Shared definitions for the two-requester merge scheduler.
//   DATA_W_DEF : default token width
//   COUNT_ONE  : Out1_COUNT value while a token is held
//   GRANT_*    : one-hot grant encodings
//   state_e    : arbiter FSM states (encoded to match the grant they drive)
package ll1_merge_scheduler_pkg;

    localparam int          DATA_W_DEF = 16;
    localparam logic [15:0] COUNT_ONE  = 16'h1;

    localparam logic [1:0] GRANT_IDLE = 2'b00;
    localparam logic [1:0] GRANT_IN1  = 2'b01;
    localparam logic [1:0] GRANT_IN2  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SERVE1 = 2'b01,
        ST_SERVE2 = 2'b10
    } state_e;

endpackage

// File: rtl/ll1_out_slot.sv
// One-deep output register for the merged token stream.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i/data_i : capture a new token (wins over ack_i in the same cycle)
//   ack_i         : downstream consumed the held token
//   vld_o/data_o  : held token valid / data (data stable until replaced)
//   count_o       : COUNT_ONE while valid, else zero
module ll1_out_slot
    import ll1_merge_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ack_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic [15:0]       count_o
);

    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
        end else if (ack_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign count_o = vld_q ? COUNT_ONE : 16'h0;

endmodule

// File: rtl/ll1_merge_scheduler.sv
// Merges two token streams into one, granting a requester for up to BURST
// tokens at a time and alternating between requesters when both are active.
//   CLK, RESET                       : clock, async active-low reset
//   In1_/In2_ DATA, SEND, COUNT, ACK : requester streams (COUNT ignored)
//   Out1_ DATA, SEND, COUNT          : registered merged output
//   Out1_ACK, Out1_RDY               : downstream consume / ready
//   Grant                            : one-hot current grant (00 idle)
module ll1_merge_scheduler
    import ll1_merge_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BURST  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic              In1_SEND,
    input  logic [15:0]       In1_COUNT,
    output logic              In1_ACK,
    input  logic [DATA_W-1:0] In2_DATA,
    input  logic              In2_SEND,
    input  logic [15:0]       In2_COUNT,
    output logic              In2_ACK,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic              Out1_SEND,
    output logic [15:0]       Out1_COUNT,
    input  logic              Out1_ACK,
    input  logic              Out1_RDY,
    output logic [1:0]        Grant
);

    localparam logic [7:0] BURST_C = 8'(BURST);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last2_q, last2_d;   // 1: In2 was served last
    logic        serving2, own_send, other_send;
    logic        slot_free, accept;
    logic [7:0]  cnt_inc;
    logic        unused_counts;

    assign unused_counts = ^{In1_COUNT, In2_COUNT};

    // A held token being consumed this cycle frees the slot for a new one.
    assign slot_free  = !Out1_SEND || Out1_ACK;
    assign serving2   = (state_q == ST_SERVE2);
    assign own_send   = serving2 ? In2_SEND : In1_SEND;
    assign other_send = serving2 ? In1_SEND : In2_SEND;
    assign accept     = (state_q != ST_IDLE) && own_send && Out1_RDY && slot_free;
    assign cnt_inc    = cnt_q + 8'd1;

    assign In1_ACK = accept && !serving2;
    assign In2_ACK = accept &&  serving2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last2_d = last2_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                // On a tie the requester not served last wins.
                if (In1_SEND && (!In2_SEND || last2_q))
                    state_d = ST_SERVE1;
                else if (In2_SEND)
                    state_d = ST_SERVE2;
            end
            ST_SERVE1, ST_SERVE2: begin
                if (accept)
                    cnt_d = cnt_inc;
                // A stall (RDY low or slot full) with SEND high holds state.
                if (!own_send || (accept && cnt_inc == BURST_C)) begin
                    last2_d = serving2;
                    cnt_d   = 8'd0;
                    if (other_send)
                        state_d = serving2 ? ST_SERVE1 : ST_SERVE2;
                    else if (own_send)
                        state_d = state_q;
                    else
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            last2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last2_q <= last2_d;
        end
    end

    assign Grant = (state_q == ST_SERVE1) ? GRANT_IN1 :
                   (state_q == ST_SERVE2) ? GRANT_IN2 : GRANT_IDLE;

    ll1_out_slot #(.DATA_W(DATA_W)) u_slot (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .load_i  (accept),
        .data_i  (serving2 ? In2_DATA : In1_DATA),
        .ack_i   (Out1_ACK),
        .vld_o   (Out1_SEND),
        .data_o  (Out1_DATA),
        .count_o (Out1_COUNT)
    );

endmodule

// File: tb/tb_ll1_merge_scheduler.sv
module tb_ll1_merge_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    always #5 CLK = ~CLK;

    // BURST=4 instance
    logic [15:0] In1_DATA, In2_DATA, In1_COUNT, In2_COUNT, Out1_DATA, Out1_COUNT;
    logic        In1_SEND, In2_SEND, In1_ACK, In2_ACK, Out1_SEND, Out1_ACK, Out1_RDY;
    logic [1:0]  Grant;
    // BURST=1 instance
    logic [15:0] b_In1_DATA, b_In2_DATA, b_Out1_DATA, b_Out1_COUNT;
    logic        b_In1_SEND, b_In2_SEND, b_In1_ACK, b_In2_ACK, b_Out1_SEND;
    logic [1:0]  b_Grant;

    int checks = 0;
    int errors = 0;
    int i1, i2;

    ll1_merge_scheduler #(.DATA_W(16), .BURST(4)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT), .In1_ACK(In1_ACK),
        .In2_DATA(In2_DATA), .In2_SEND(In2_SEND), .In2_COUNT(In2_COUNT), .In2_ACK(In2_ACK),
        .Out1_DATA(Out1_DATA), .Out1_SEND(Out1_SEND), .Out1_COUNT(Out1_COUNT),
        .Out1_ACK(Out1_ACK), .Out1_RDY(Out1_RDY), .Grant(Grant)
    );

    ll1_merge_scheduler #(.DATA_W(16), .BURST(1)) u_dut_b1 (
        .CLK(CLK), .RESET(RESET),
        .In1_DATA(b_In1_DATA), .In1_SEND(b_In1_SEND), .In1_COUNT(16'h0), .In1_ACK(b_In1_ACK),
        .In2_DATA(b_In2_DATA), .In2_SEND(b_In2_SEND), .In2_COUNT(16'h0), .In2_ACK(b_In2_ACK),
        .Out1_DATA(b_Out1_DATA), .Out1_SEND(b_Out1_SEND), .Out1_COUNT(b_Out1_COUNT),
        .Out1_ACK(1'b1), .Out1_RDY(1'b1), .Grant(b_Grant)
    );

    // Hand-computed per-cycle expectations.
    // A: In1 alone, tokens 0x11..0x16
    logic [1:0]  a_g [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic        a_a [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        a_s [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] a_d [9] = '{16'h0, 16'h0, 16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h0};
    // D: RDY stall mid-burst, both requesters
    logic        d_r  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0]  d_g  [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic        d_a1 [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        d_a2 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        d_s  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] d_d  [10] = '{16'h0, 16'h0, 16'h100, 16'h101, 16'h0, 16'h0, 16'h0, 16'h102, 16'h103, 16'h200};
    // F: BURST=1 alternation, In1 drops at cycle 5
    logic        f_s1 [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  f_g  [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
    logic        f_a1 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        f_a2 [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        f_s  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] f_d  [8] = '{16'h0, 16'h0, 16'h300, 16'h400, 16'h301, 16'h401, 16'h0, 16'h402};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_cyc(input string tag,
                           input logic [1:0] og, input logic oa1, input logic oa2,
                           input logic os, input logic [15:0] oc, input logic [15:0] od,
                           input logic [1:0] eg, input logic ea1, input logic ea2,
                           input logic es, input logic [15:0] ed);
        chk({tag, " grant"}, 32'(og),  32'(eg));
        chk({tag, " ack1"},  32'(oa1), 32'(ea1));
        chk({tag, " ack2"},  32'(oa2), 32'(ea2));
        chk({tag, " send"},  32'(os),  32'(es));
        chk({tag, " count"}, 32'(oc),  es ? 32'h1 : 32'h0);
        if (es) chk({tag, " data"}, 32'(od), 32'(ed));
    endtask

    task automatic exp_m(input string tag, input logic [1:0] eg, input logic ea1,
                         input logic ea2, input logic es, input logic [15:0] ed);
        exp_cyc(tag, Grant, In1_ACK, In2_ACK, Out1_SEND, Out1_COUNT, Out1_DATA,
                eg, ea1, ea2, es, ed);
    endtask

    task automatic exp_b(input string tag, input logic [1:0] eg, input logic ea1,
                         input logic ea2, input logic es, input logic [15:0] ed);
        exp_cyc(tag, b_Grant, b_In1_ACK, b_In2_ACK, b_Out1_SEND, b_Out1_COUNT, b_Out1_DATA,
                eg, ea1, ea2, es, ed);
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clr_inputs();
        In1_SEND = 1'b0; In2_SEND = 1'b0; In1_DATA = '0; In2_DATA = '0;
        In1_COUNT = 16'h5; In2_COUNT = 16'h7;
        Out1_RDY = 1'b1; Out1_ACK = 1'b1;
        b_In1_SEND = 1'b0; b_In2_SEND = 1'b0; b_In1_DATA = '0; b_In2_DATA = '0;
    endtask

    // Entered and left at a falling edge; releases reset on that edge.
    task automatic do_reset();
        RESET = 1'b0;
        clr_inputs();
        cyc();
        RESET = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0;
        clr_inputs();
        @(negedge CLK);
        #1;
        exp_m("rst", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst data", 32'(Out1_DATA), 32'h0);
        exp_b("rst_b1", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        cyc();
        RESET = 1'b1;

        // A: single requester, back-to-back bursts with no idle gap
        i1 = 0;
        for (int c = 0; c < 9; c++) begin
            In1_SEND = (i1 < 6);
            In1_DATA = 16'h11 + 16'(i1);
            #1;
            exp_m($sformatf("A%0d", c), a_g[c], a_a[c], 1'b0, a_s[c], a_d[c]);
            if (In1_ACK) i1++;
            cyc();
        end

        // B: both requesters, BURST=4 alternation
        do_reset();
        i1 = 0; i2 = 0;
        In1_SEND = 1'b1; In2_SEND = 1'b1;
        for (int c = 0; c < 13; c++) begin
            logic [1:0]  eg;
            logic [15:0] ed;
            int          k;
            In1_DATA = 16'h100 + 16'(i1);
            In2_DATA = 16'h200 + 16'(i2);
            #1;
            eg = (c == 0) ? 2'd0 : ((((c - 1) / 4) % 2 == 0) ? 2'd1 : 2'd2);
            k  = c - 2;
            ed = (((k / 4) % 2 == 1) ? 16'h200 : 16'h100) + 16'((k / 8) * 4 + k % 4);
            exp_m($sformatf("B%0d", c), eg, eg == 2'd1, eg == 2'd2, c >= 2, ed);
            if (In1_ACK) i1++;
            if (In2_ACK) i2++;
            cyc();
        end

        // C: downstream holds ACK low for 5 cycles with 0x00AA in the slot
        do_reset();
        In1_SEND = 1'b1; In1_DATA = 16'h00AA; Out1_ACK = 1'b0;
        #1; exp_m("C0", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0); cyc();
        #1; exp_m("C1", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0); cyc();
        In1_DATA = 16'h00BB;
        for (int c = 2; c < 7; c++) begin
            #1; exp_m($sformatf("C%0d", c), 2'd1, 1'b0, 1'b0, 1'b1, 16'h00AA); cyc();
        end
        Out1_ACK = 1'b1;
        #1; exp_m("C7", 2'd1, 1'b1, 1'b0, 1'b1, 16'h00AA); cyc();
        In1_SEND = 1'b0;
        #1; exp_m("C8", 2'd1, 1'b0, 1'b0, 1'b1, 16'h00BB); cyc();
        #1; exp_m("C9", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0); cyc();

        // D: Out1_RDY low after two accepts, then resume and switch
        do_reset();
        i1 = 0; i2 = 0;
        In1_SEND = 1'b1; In2_SEND = 1'b1;
        for (int c = 0; c < 10; c++) begin
            Out1_RDY = d_r[c];
            In1_DATA = 16'h100 + 16'(i1);
            In2_DATA = 16'h200 + 16'(i2);
            #1;
            exp_m($sformatf("D%0d", c), d_g[c], d_a1[c], d_a2[c], d_s[c], d_d[c]);
            if (In1_ACK) i1++;
            if (In2_ACK) i2++;
            if (c < 9) cyc();
        end

        // E: reset while holding a token under grant 10
        RESET = 1'b0;
        #1;
        exp_m("E0", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("E0 data", 32'(Out1_DATA), 32'h0);
        cyc();
        #1;
        exp_m("E1", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("E1 data", 32'(Out1_DATA), 32'h0);
        cyc();
        RESET = 1'b1;
        #1; exp_m("E2", 2'd0, 1'b0, 1'b0, 1'b0, 16'h0); cyc();
        #1; exp_m("E3", 2'd1, 1'b1, 1'b0, 1'b0, 16'h0); cyc();

        // F: BURST=1 alternation, In1 drops SEND while granted
        do_reset();
        i1 = 0; i2 = 0;
        b_In2_SEND = 1'b1;
        for (int c = 0; c < 8; c++) begin
            b_In1_SEND = f_s1[c];
            b_In1_DATA = 16'h300 + 16'(i1);
            b_In2_DATA = 16'h400 + 16'(i2);
            #1;
            exp_b($sformatf("F%0d", c), f_g[c], f_a1[c], f_a2[c], f_s[c], f_d[c]);
            if (b_In1_ACK) i1++;
            if (b_In2_ACK) i2++;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
